hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed-depth 5-stage hazard unit.
- Tracks in-flight register writers in a per-stage shift record: DEPTH-1 slots from execute onward.
- Each cycle it resolves every decode source operand to one of three outcomes: forward from stage k, read the register file, or stall.
- Sits beside decode. It owns RAW stall/bubble generation, flush-depth squashing and a stall-cycle performance counter for any pipeline depth and any source count.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_src_match.sv | 38 +++
 rtl/hazard_scoreboard.sv | 83 ++++++++
 tb/tb_hazard_scoreboard.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the parametrised hazard scoreboard.
// Slot fields are stored at fixed maximum widths; narrower AW/LW values are zero-extended.
package hazard_pkg;

  localparam int SLOT_AW = 8;
  localparam int SLOT_LW = 4;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] dst;
    logic [SLOT_LW-1:0] lat;
  } slot_t;

  localparam int FWD_RF   = 0;
  localparam int SLOT_E   = 1;
  localparam int SLOT_M   = 2;
  localparam int SLOT_W   = 3;
  localparam int LAT_ALU  = 2;
  localparam int LAT_LOAD = 3;

endpackage

// File: rtl/hazard_src_match.sv
// Resolves one decode source against the in-flight slot record.
// The youngest matching writer decides the outcome, even if an older one is ready.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int LW    = 2
) (
  input  slot_t [DEPTH-1:1] slots_i,
  input  logic [AW-1:0]     src_i,
  input  logic              used_i,
  output logic              hit_o,
  output logic              ready_o,
  output logic [LW-1:0]     sel_o
);

  logic rdy;

  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    sel_o   = LW'(FWD_RF);
    rdy     = 1'b0;
    if (used_i && (src_i != '0)) begin
      // Scan oldest to youngest so the lowest-index match is the last one written.
      for (int k = DEPTH-1; k >= 1; k--) begin
        if (slots_i[k].valid && (slots_i[k].dst == SLOT_AW'(src_i))) begin
          rdy     = (SLOT_LW'(k) >= slots_i[k].lat);
          hit_o   = 1'b1;
          ready_o = rdy;
          sel_o   = rdy ? LW'(k) : LW'(FWD_RF);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard beside decode: forwarding select, stall generation,
// flush squashing and a saturating stall-cycle counter. AW/LW must fit SLOT_AW/SLOT_LW.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int LW      = 2,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  input  logic                  issue_we_i,
  input  logic [AW-1:0]         issue_dst_i,
  input  logic [LW-1:0]         issue_lat_i,
  input  logic [NUM_SRC*AW-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]    src_used_i,
  input  logic                  pipe_adv_i,
  input  logic                  flush_i,
  input  logic [LW-1:0]         flush_depth_i,
  output logic                  stall_o,
  output logic [NUM_SRC*LW-1:0] fwd_sel_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  slot_t [DEPTH-1:1] slots_q, slots_d, squashed;
  logic  [NUM_SRC-1:0] hit, rdy;
  logic  [CNT_W-1:0]   cnt_q;
  logic                load;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    hazard_src_match #(
      .DEPTH(DEPTH),
      .AW   (AW),
      .LW   (LW)
    ) u_match (
      .slots_i(slots_q),
      .src_i  (src_addr_i[j*AW +: AW]),
      .used_i (src_used_i[j]),
      .hit_o  (hit[j]),
      .ready_o(rdy[j]),
      .sel_o  (fwd_sel_o[j*LW +: LW])
    );
  end

  assign stall_o = issue_valid_i & (|(hit & ~rdy));
  assign load    = issue_valid_i & issue_we_i & (issue_dst_i != '0) & ~stall_o & ~flush_i;

  always_comb begin
    squashed = slots_q;
    // Squash uses pre-shift indices; survivors move only when the pipe advances.
    if (flush_i) begin
      for (int k = 1; k <= DEPTH-1; k++) begin
        if (LW'(k) < flush_depth_i) squashed[k].valid = 1'b0;
      end
    end
    slots_d = squashed;
    if (pipe_adv_i) begin
      for (int k = 2; k <= DEPTH-1; k++) slots_d[k] = squashed[k-1];
      slots_d[1] = '0;
      if (load) begin
        slots_d[1].valid = 1'b1;
        slots_d[1].dst   = SLOT_AW'(issue_dst_i);
        slots_d[1].lat   = SLOT_LW'(issue_lat_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      if (stall_o && pipe_adv_i && !flush_i && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  localparam int DEPTH = 4, NUM_SRC = 2, AW = 5, LW = 2, CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  issue_valid_i, issue_we_i;
  logic [AW-1:0]         issue_dst_i;
  logic [LW-1:0]         issue_lat_i;
  logic [NUM_SRC*AW-1:0] src_addr_i;
  logic [NUM_SRC-1:0]    src_used_i;
  logic                  pipe_adv_i, flush_i;
  logic [LW-1:0]         flush_depth_i;
  logic                  stall_o;
  logic [NUM_SRC*LW-1:0] fwd_sel_o;
  logic [CNT_W-1:0]      stall_cnt_o;

  hazard_scoreboard #(
    .DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .AW(AW), .LW(LW), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid_i(issue_valid_i),
    .issue_we_i   (issue_we_i),
    .issue_dst_i  (issue_dst_i),
    .issue_lat_i  (issue_lat_i),
    .src_addr_i   (src_addr_i),
    .src_used_i   (src_used_i),
    .pipe_adv_i   (pipe_adv_i),
    .flush_i      (flush_i),
    .flush_depth_i(flush_depth_i),
    .stall_o      (stall_o),
    .fwd_sel_o    (fwd_sel_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic v, input logic we, input logic [AW-1:0] dst,
                             input logic [LW-1:0] lat);
    issue_valid_i = v;
    issue_we_i    = we;
    issue_dst_i   = dst;
    issue_lat_i   = lat;
  endtask

  task automatic drive_src(input logic [AW-1:0] a0, input logic u0,
                           input logic [AW-1:0] a1, input logic u1);
    src_addr_i = {a1, a0};
    src_used_i = {u1, u0};
  endtask

  task automatic idle();
    drive_issue(1'b0, 1'b0, '0, '0);
    drive_src('0, 1'b0, '0, 1'b0);
    pipe_adv_i    = 1'b1;
    flush_i       = 1'b0;
    flush_depth_i = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_fwd", 32'(fwd_sel_o), 32'd0);
    chk("rst_cnt", stall_cnt_o, 32'd0);

    // ALU back-to-back
    drive_issue(1'b1, 1'b1, 5'd5, 2'd2);
    #2 chk("alu_issue_stall", 32'(stall_o), 32'd0);
    tick();
    drive_issue(1'b1, 1'b0, '0, '0);
    drive_src(5'd5, 1'b1, '0, 1'b0);
    #2 chk("alu_stall", 32'(stall_o), 32'd1);
    chk("alu_fwd_hz", 32'(fwd_sel_o), 32'd0);
    tick();
    #2 chk("alu_fwd", 32'(fwd_sel_o), 32'h2);
    chk("alu_nostall", 32'(stall_o), 32'd0);
    chk("alu_cnt", stall_cnt_o, 32'd1);
    tick();
    idle();
    tick();

    // Load-use on src1
    drive_issue(1'b1, 1'b1, 5'd8, 2'd3);
    tick();
    drive_issue(1'b1, 1'b0, '0, '0);
    drive_src('0, 1'b0, 5'd8, 1'b1);
    #2 chk("lu_stall1", 32'(stall_o), 32'd1);
    tick();
    #2 chk("lu_stall2", 32'(stall_o), 32'd1);
    tick();
    #2 chk("lu_fwd", 32'(fwd_sel_o), 32'hC);
    chk("lu_nostall", 32'(stall_o), 32'd0);
    chk("lu_cnt", stall_cnt_o, 32'd3);
    idle();
    tick();

    // WAW: r3 ready in slot 3, younger r3 not ready in slot 1
    drive_issue(1'b1, 1'b1, 5'd3, 2'd2);
    tick();
    drive_issue(1'b0, 1'b0, '0, '0);
    tick();
    drive_issue(1'b1, 1'b1, 5'd3, 2'd2);
    tick();
    drive_issue(1'b1, 1'b1, 5'd4, 2'd2);
    drive_src(5'd3, 1'b1, 5'd4, 1'b1);
    flush_i       = 1'b1;
    flush_depth_i = 2'd0;
    #2 chk("waw_stall", 32'(stall_o), 32'd1);
    chk("waw_fwd", 32'(fwd_sel_o), 32'd0);
    tick();
    // Depth-0 flush: nothing squashed, but the r4 issue was suppressed
    flush_i = 1'b0;
    drive_issue(1'b1, 1'b0, '0, '0);
    #2 chk("f0_fwd", 32'(fwd_sel_o), 32'h2);
    chk("f0_stall", 32'(stall_o), 32'd0);
    chk("f0_cnt", stall_cnt_o, 32'd3);
    idle();
    tick();
    tick();

    // Global stall with r7 hazard pending
    drive_issue(1'b1, 1'b1, 5'd7, 2'd3);
    tick();
    drive_issue(1'b1, 1'b1, 5'd12, 2'd2);
    drive_src(5'd7, 1'b1, '0, 1'b0);
    pipe_adv_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2 chk("gs_stall", 32'(stall_o), 32'd1);
      tick();
    end
    #2 chk("gs_hold_fwd", 32'(fwd_sel_o), 32'd0);
    chk("gs_hold_cnt", stall_cnt_o, 32'd3);
    pipe_adv_i = 1'b1;
    tick();
    #2 chk("gs_stall2", 32'(stall_o), 32'd1);
    tick();
    #2 chk("gs_fwd3", 32'(fwd_sel_o), 32'h3);
    chk("gs_cnt", stall_cnt_o, 32'd5);
    idle();
    tick();

    // Flush depth 3 with advance: everything squashed or retired
    drive_issue(1'b1, 1'b1, 5'd11, 2'd2);
    tick();
    drive_issue(1'b1, 1'b1, 5'd10, 2'd2);
    tick();
    drive_issue(1'b1, 1'b1, 5'd9, 2'd2);
    tick();
    drive_issue(1'b1, 1'b1, 5'd13, 2'd2);
    drive_src(5'd9, 1'b1, 5'd11, 1'b1);
    #2 chk("fl_pre_stall", 32'(stall_o), 32'd1);
    chk("fl_pre_fwd", 32'(fwd_sel_o), 32'hC);
    flush_i       = 1'b1;
    flush_depth_i = 2'd3;
    tick();
    flush_i = 1'b0;
    drive_issue(1'b1, 1'b0, '0, '0);
    #2 chk("fl_stall", 32'(stall_o), 32'd0);
    chk("fl_fwd", 32'(fwd_sel_o), 32'd0);
    chk("fl_cnt", stall_cnt_o, 32'd5);
    drive_src(5'd10, 1'b1, 5'd13, 1'b1);
    #1 chk("fl_fwd2", 32'(fwd_sel_o), 32'd0);
    chk("fl_stall2", 32'(stall_o), 32'd0);
    idle();
    tick();

    // Flush without advance squashes slot 1 in place; slot 2 stays
    drive_issue(1'b1, 1'b1, 5'd14, 2'd3);
    tick();
    drive_issue(1'b1, 1'b1, 5'd15, 2'd2);
    tick();
    drive_issue(1'b0, 1'b0, '0, '0);
    flush_i       = 1'b1;
    flush_depth_i = 2'd2;
    pipe_adv_i    = 1'b0;
    tick();
    flush_i    = 1'b0;
    pipe_adv_i = 1'b1;
    drive_issue(1'b1, 1'b0, '0, '0);
    drive_src(5'd14, 1'b1, 5'd15, 1'b1);
    #2 chk("fi_stall", 32'(stall_o), 32'd1);
    chk("fi_fwd", 32'(fwd_sel_o), 32'd0);
    chk("fi_cnt", stall_cnt_o, 32'd5);

    // Reset while stalled
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2 chk("rs_stall", 32'(stall_o), 32'd0);
    chk("rs_cnt", stall_cnt_o, 32'd0);
    chk("rs_fwd", 32'(fwd_sel_o), 32'd0);

    // Register 0 is never tracked
    drive_issue(1'b1, 1'b1, 5'd0, 2'd2);
    drive_src('0, 1'b0, '0, 1'b0);
    tick();
    drive_issue(1'b1, 1'b0, '0, '0);
    drive_src(5'd0, 1'b1, 5'd0, 1'b1);
    #2 chk("z_stall", 32'(stall_o), 32'd0);
    chk("z_fwd", 32'(fwd_sel_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
